mips_mc_core: RTL and testbench
===============================

Name: mips_mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS datapath.
- Shares one ALU and one unified instruction/data memory port across a per-instruction state machine.
- Adds a request/ready memory handshake with arbitrary wait states, a configurable reset vector and address width, an illegal-instruction halt, and a per-instruction retire pulse.
- Sits between the top level and an external unified memory model.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into pc on reset.
- ADDR_W, 16, width of the word-address memory port; mem_addr = byte_addr[ADDR_W+1:2].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req=1.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the cycle mem_req&mem_ready=1.
- mem_ready  in  1  memory completes the current request this cycle.
- pc  out  32  current instruction byte address.
- instr  out  32  latched instruction register.
- state  out  4  current FSM state code, for debug.
- halted  out  1  sticky illegal-instruction flag.
- retire  out  1  one-cycle pulse when an instruction commits.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, instr=0, state=FETCH.
  - All register-file entries cleared to 0.
  - halted=0, retire=0, mem_req=0.
  - Any in-flight memory transaction is abandoned immediately.
- First fetch starts in the first clk edge window after reset deasserts.
- Supported ISA:
  - R-type add/sub/and/or/slt/sll/srl (funct 20/22/24/25/2A/00/02 hex).
  - lw(23), sw(2B), beq(04), bne(05), addi(08), j(02) (opcodes hex).
- Anything else, including an unknown funct, is illegal.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are driven from registered state and held stable until a cycle with mem_req&mem_ready.
  - The transaction completes on that rising edge.
  - mem_req=1 only in FETCH, MEMRD and MEMWR.
  - mem_ready while mem_req=0 is ignored.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, addr=pc. On ready, latch instr and pc_plus4=pc+4, then go to DECODE; otherwise stay.
  - DECODE: read rs/rt into A/B and compute the branch target pc_plus4 + (sext(imm)<<2). Dispatch to MEMADR (lw/sw), EXEC (R), ADDIEX, BRANCH, JUMP or HALT.
  - MEMADR: ALUOut = A + sext(imm). Go to MEMRD (lw) or MEMWR (sw).
  - MEMRD: read at ALUOut; on ready latch data and go to MEMWB.
  - MEMWB: rt <= data; retire; go to FETCH.
  - MEMWR: write B to ALUOut; on ready, retire and go to FETCH.
  - EXEC: ALUOut = A op B; sll/srl shift B by shamt. Go to ALUWB.
  - ALUWB: rd <= ALUOut; pc <= pc_plus4; retire; go to FETCH.
  - ADDIEX → ADDIWB: rt <= A + sext(imm); retire.
  - BRANCH: pc <= target if (beq & A==B) | (bne & A!=B), else pc_plus4; retire.
  - JUMP: pc <= {pc_plus4[31:28], instr[25:0], 2'b00}; retire.
  - HALT: terminal. halted=1, mem_req=0, no register writes, pc holds the offending instruction's address. Only reset exits.
- pc update: the non-branch/non-jump paths update pc to pc_plus4 in their retire state.
- Cycles per instruction with zero wait states (mem_ready tied 1):
  - R: 4. addi: 4. lw: 5. sw: 4. beq/bne: 3. j: 3.
  - Each memory wait cycle adds 1.
- Arithmetic:
  - 32-bit, wrap-around; no overflow trap.
  - slt is signed, result 0 or 1.
  - Byte-address bits [1:0] are ignored, so unaligned accesses are word-truncated.
  - pc wraps modulo 2^32.
- Register $0 reads as 0; writes to $0 are discarded. retire still pulses.

Decomposition:
- Package mips_pkg holds:
  - Opcode and funct constants.
  - State encoding (4-bit localparams).
  - ALU operation codes.
- One sub-module, mips_regfile:
  - 32x32, two asynchronous read ports, one synchronous write port.
  - Asynchronous active-low clear; $0 hardwired to 0.
- ALU, sign-extend and the FSM stay inline.

Test Plan:
- Zero-wait program "addi $1,$0,5; addi $2,$0,7; add $3,$1,$2" → $3=12. retire pulses at cycles 4, 8 and 12 after the first fetch.
- "sw $3,8($0)" then "lw $4,8($0)" with mem_ready low for 3 cycles per request → mem_addr=2, mem_wdata=12 held for 4 cycles; $4=12; lw takes 8 cycles.
- "beq $1,$1,+2" at pc 0x10 → pc=0x1C after 3 cycles. "bne $1,$1,+2" → pc=0x14.
- "j 0x40" at pc 0x10000000 → pc=0x10000100. "sll $5,$1,4" → 0x50. "slt $6,$7(=-1),$0" → 1.
- Opcode 0x3F at pc 0x20 → halted=1, pc=0x20, no further mem_req, registers unchanged. Reset low → halted=0, pc=RESET_PC.
- Reset asserted mid-MEMWR with mem_ready=0 → mem_req drops the same cycle, no write occurs, FETCH from RESET_PC after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: ISA fields, FSM states, ALU ops.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,  S_ADDIWB = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_t;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_op_t funct_op(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two async read ports, one sync write port, $0 hardwired to zero.
module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS core sharing one ALU and one unified memory port with a req/ready handshake.
module mips_mc_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic [3:0]        state,
  output logic              halted,
  output logic              retire
);

  state_t      state_q, dispatch_c;
  alu_op_t     alu_op_c;
  logic [31:0] pc_plus4, target, a, b, aluout, mdr;
  logic [31:0] simm_c, rd1_c, rd2_c, alu_b_c, alu_y_c, next_pc_c, rf_wdata_c;
  logic [5:0]  opcode_c, funct_c;
  logic [4:0]  rs_c, rt_c, rd_c, shamt_c, rf_waddr_c;
  logic        taken_c, commit_c, rf_we_c;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[ADDR_W+1:2];
  endfunction

  assign opcode_c = instr[31:26];
  assign rs_c     = instr[25:21];
  assign rt_c     = instr[20:16];
  assign rd_c     = instr[15:11];
  assign shamt_c  = instr[10:6];
  assign funct_c  = instr[5:0];
  assign simm_c   = {{16{instr[15]}}, instr[15:0]};
  assign state    = state_q;

  mips_regfile u_rf (
    .clk    (clk),
    .rst_n  (reset),
    .raddr1 (rs_c),
    .raddr2 (rt_c),
    .rdata1 (rd1_c),
    .rdata2 (rd2_c),
    .we     (rf_we_c),
    .waddr  (rf_waddr_c),
    .wdata  (rf_wdata_c)
  );

  // Shared ALU: R-type ops in EXEC, address/immediate add everywhere else.
  always_comb begin
    alu_b_c  = (state_q == S_EXEC) ? b : simm_c;
    alu_op_c = (state_q == S_EXEC) ? funct_op(funct_c) : ALU_ADD;
    case (alu_op_c)
      ALU_SUB: alu_y_c = a - alu_b_c;
      ALU_AND: alu_y_c = a & alu_b_c;
      ALU_OR:  alu_y_c = a | alu_b_c;
      ALU_SLT: alu_y_c = 32'($signed(a) < $signed(alu_b_c));
      ALU_SLL: alu_y_c = alu_b_c << shamt_c;
      ALU_SRL: alu_y_c = alu_b_c >> shamt_c;
      default: alu_y_c = a + alu_b_c;
    endcase
  end

  always_comb begin
    dispatch_c = S_HALT;
    case (opcode_c)
      OP_RTYPE:     dispatch_c = funct_legal(funct_c) ? S_EXEC : S_HALT;
      OP_LW, OP_SW: dispatch_c = S_MEMADR;
      OP_ADDI:      dispatch_c = S_ADDIEX;
      OP_BEQ, OP_BNE: dispatch_c = S_BRANCH;
      OP_J:         dispatch_c = S_JUMP;
      default:      dispatch_c = S_HALT;
    endcase
  end

  // Retire-state pc selection and register write-back.
  always_comb begin
    taken_c    = ((opcode_c == OP_BEQ) && (a == b)) || ((opcode_c == OP_BNE) && (a != b));
    next_pc_c  = pc_plus4;
    commit_c   = 1'b0;
    rf_we_c    = 1'b0;
    rf_waddr_c = rt_c;
    rf_wdata_c = aluout;
    case (state_q)
      S_MEMWB:  begin commit_c = 1'b1; rf_we_c = 1'b1; rf_wdata_c = mdr; end
      S_ALUWB:  begin commit_c = 1'b1; rf_we_c = 1'b1; rf_waddr_c = rd_c; end
      S_ADDIWB: begin commit_c = 1'b1; rf_we_c = 1'b1; end
      S_MEMWR:  commit_c = mem_ready;
      S_BRANCH: begin commit_c = 1'b1; if (taken_c) next_pc_c = target; end
      S_JUMP:   begin commit_c = 1'b1; next_pc_c = {pc_plus4[31:28], instr[25:0], 2'b00}; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc        <= RESET_PC;
      instr     <= '0;
      pc_plus4  <= '0;
      target    <= '0;
      a         <= '0;
      b         <= '0;
      aluout    <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      retire    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state_q)
        S_FETCH: begin
          // The first cycle out of reset only launches the fetch request.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= word_addr(pc);
          end else if (mem_ready) begin
            mem_req  <= 1'b0;
            instr    <= mem_rdata;
            pc_plus4 <= pc + 32'd4;
            state_q  <= S_DECODE;
          end
        end
        S_DECODE: begin
          a       <= rd1_c;
          b       <= rd2_c;
          target  <= pc_plus4 + (simm_c << 2);
          state_q <= dispatch_c;
          halted  <= (dispatch_c == S_HALT);
        end
        S_MEMADR: begin
          aluout    <= alu_y_c;
          mem_req   <= 1'b1;
          mem_we    <= (opcode_c == OP_SW);
          mem_addr  <= word_addr(alu_y_c);
          mem_wdata <= b;
          state_q   <= (opcode_c == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mdr     <= mem_rdata;
            state_q <= S_MEMWB;
          end
        end
        S_EXEC:   begin aluout <= alu_y_c; state_q <= S_ALUWB;  end
        S_ADDIEX: begin aluout <= alu_y_c; state_q <= S_ADDIWB; end
        S_HALT:   ;
        default:  ;
      endcase
      if (commit_c) begin
        pc       <= next_pc_c;
        retire   <= 1'b1;
        state_q  <= S_FETCH;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= word_addr(next_pc_c);
      end
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench: program in a wait-state memory model, retire scoreboard, reset/halt checks.
module tb_mips_mc_core;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_req, m_we, m_ready, retire, halted;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_rdata, pc, instr;
  logic [3:0]  dstate;

  logic        req2, we2, retire2, halted2;
  logic [15:0] addr2;
  logic [31:0] wdata2, rdata2, pc2, instr2;
  logic [3:0]  state2;

  always #5 clk = ~clk;

  mips_mc_core #(.RESET_PC(32'h0000_0000), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .mem_req(m_req), .mem_we(m_we), .mem_addr(m_addr),
    .mem_wdata(m_wdata), .mem_rdata(m_rdata), .mem_ready(m_ready), .pc(pc),
    .instr(instr), .state(dstate), .halted(halted), .retire(retire)
  );

  mips_mc_core #(.RESET_PC(32'h1000_0000), .ADDR_W(16)) dut2 (
    .clk(clk), .reset(reset), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ready(1'b1), .pc(pc2),
    .instr(instr2), .state(state2), .halted(halted2), .retire(retire2)
  );

  // Second core: j 0x40 at its reset vector, zeros (sll $0 nops) elsewhere.
  assign rdata2 = (addr2 == 16'h0000) ? {6'h02, 26'h40} : 32'h0;

  logic [31:0] mem [256];
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'd0;
  logic [31:0] load_data = 32'd0;
  int          cnt = 0, data_wait = 0, wr_count = 0, we_cyc = 0, hold_cyc = 0;
  logic        j_seen = 1'b0;
  logic [31:0] j_pc = 32'd0;

  assign m_rdata = mem[m_addr[7:0]];
  assign m_ready = m_req && (cnt >= (((dstate == S_MEMRD) || (dstate == S_MEMWR)) ? data_wait : 0));

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (m_req && m_ready) begin
      cnt <= 0;
      if (m_we) begin
        mem[m_addr[7:0]] <= m_wdata;
        wr_count <= wr_count + 1;
      end
    end else if (m_req) cnt <= cnt + 1;
    else cnt <= 0;
  end

  always @(negedge clk) begin
    if (m_req && m_we) begin
      we_cyc <= we_cyc + 1;
      if (m_addr == 16'd2 && m_wdata == 32'd12) hold_cyc <= hold_cyc + 1;
    end
    if (retire2 && !j_seen) begin
      j_seen <= 1'b1;
      j_pc   <= pc2;
    end
  end

  typedef struct { logic [31:0] pc; int r; logic [31:0] v; int cyc; } exp_t;
  exp_t        sbq[$];
  logic [31:0] prog [256];
  int          checks = 0, errors = 0;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.u_rf.regs[5'(i)];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] p, input int r, input logic [31:0] v, input int c);
    exp_t e;
    e.pc = p; e.r = r; e.v = v; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic load_all();
    load_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      load_addr = 8'(i);
      load_data = prog[i];
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  task automatic expect_retire(input string tag);
    exp_t e;
    int   n;
    n = 0;
    do begin step(); n++; end while (retire !== 1'b1 && n < 40);
    chk({tag, "_retire"}, 32'(retire), 32'd1);
    if (sbq.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      e = sbq.pop_front();
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_reg"}, rf(e.r), e.v);
      chk({tag, "_cycles"}, 32'(n), 32'(e.cyc));
    end
  endtask

  initial begin
    int n, wr_before, req_seen;

    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
    prog[0]  = itype(OP_ADDI, 5'd0, 5'd1, 16'd5);
    prog[1]  = itype(OP_ADDI, 5'd0, 5'd2, 16'd7);
    prog[2]  = rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_ADD);
    prog[3]  = itype(OP_SW, 5'd0, 5'd3, 16'd8);
    prog[4]  = itype(OP_BEQ, 5'd1, 5'd1, 16'd2);
    prog[5]  = itype(OP_ADDI, 5'd0, 5'd14, 16'd1);
    prog[6]  = itype(OP_ADDI, 5'd0, 5'd14, 16'd1);
    prog[7]  = itype(OP_LW, 5'd0, 5'd4, 16'd8);
    prog[8]  = itype(OP_BNE, 5'd1, 5'd1, 16'd2);
    prog[9]  = rtype(5'd0, 5'd1, 5'd5, 5'd4, FN_SLL);
    prog[10] = itype(OP_ADDI, 5'd0, 5'd7, 16'hFFFF);
    prog[11] = rtype(5'd7, 5'd0, 5'd6, 5'd0, FN_SLT);
    prog[12] = rtype(5'd2, 5'd1, 5'd8, 5'd0, FN_SUB);
    prog[13] = rtype(5'd1, 5'd2, 5'd9, 5'd0, FN_OR);
    prog[14] = rtype(5'd1, 5'd2, 5'd10, 5'd0, FN_AND);
    prog[15] = rtype(5'd0, 5'd3, 5'd11, 5'd2, FN_SRL);
    prog[16] = itype(OP_BNE, 5'd1, 5'd2, 16'd1);
    prog[17] = 32'hFC00_0000;
    prog[18] = rtype(5'd1, 5'd1, 5'd0, 5'd0, FN_ADD);
    prog[19] = rtype(5'd0, 5'd7, 5'd12, 5'd0, FN_SLT);
    prog[20] = itype(OP_LW, 5'd3, 5'd13, 16'd3);
    prog[21] = 32'hFC00_0000;

    push(32'h04, 1, 32'd5, 4);          push(32'h08, 2, 32'd7, 4);
    push(32'h0C, 3, 32'd12, 4);         push(32'h10, 0, 32'd0, 7);
    push(32'h1C, 0, 32'd0, 3);          push(32'h20, 4, 32'd12, 8);
    push(32'h24, 0, 32'd0, 3);          push(32'h28, 5, 32'h50, 4);
    push(32'h2C, 7, 32'hFFFF_FFFF, 4);  push(32'h30, 6, 32'd1, 4);
    push(32'h34, 8, 32'd2, 4);          push(32'h38, 9, 32'd7, 4);
    push(32'h3C, 10, 32'd5, 4);         push(32'h40, 11, 32'd3, 4);
    push(32'h48, 0, 32'd0, 3);          push(32'h4C, 0, 32'd0, 4);
    push(32'h50, 12, 32'd0, 4);         push(32'h54, 13, itype(OP_SW, 5'd0, 5'd3, 16'd8), 8);

    data_wait = 3;
    load_all();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_state", 32'(dstate), 32'(S_FETCH));
    chk("rst_flags", {29'd0, halted, retire, m_req}, 32'd0);

    reset = 1'b1;
    n = 0;
    do begin step(); n++; end while (m_req !== 1'b1 && n < 5);
    chk("first_fetch_req", 32'(m_req), 32'd1);
    chk("first_fetch_addr", 32'(m_addr), 32'd0);

    for (int i = 0; i < 18; i++) begin
      expect_retire($sformatf("ins%0d", i));
      if (i == 3) begin
        chk("sw_hold_cycles", 32'(hold_cyc), 32'd4);
        chk("sw_we_cycles", 32'(we_cyc), 32'd4);
        chk("sw_count", 32'(wr_count), 32'd1);
        chk("sw_mem", mem[2], 32'd12);
      end
    end

    n = 0;
    while (halted !== 1'b1 && n < 10) begin step(); n++; end
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", pc, 32'h54);
    chk("halt_state", 32'(dstate), 32'(S_HALT));
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_req === 1'b1 || retire === 1'b1) req_seen++;
    end
    chk("halt_quiet", 32'(req_seen), 32'd0);
    chk("halt_regs", rf(13), itype(OP_SW, 5'd0, 5'd3, 16'd8));
    chk("skipped_reg", rf(14), 32'd0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("j_seen", 32'(j_seen), 32'd1);
    chk("j_pc", j_pc, 32'h1000_0100);

    // Reset out of HALT, then again in the middle of a stalled store.
    reset = 1'b0;
    #1;
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_regs", rf(1), 32'd0);
    load_all();
    data_wait = 20;
    reset = 1'b1;
    n = 0;
    while (dstate != S_MEMWR && n < 40) begin step(); n++; end
    chk("memwr_reached", 32'(dstate), 32'(S_MEMWR));
    step(); step();
    chk("memwr_stalled", {30'd0, m_req, m_we}, 32'd3);
    wr_before = wr_count;
    #2 reset = 1'b0;
    #1;
    chk("abort_req", 32'(m_req), 32'd0);
    chk("abort_state", 32'(dstate), 32'(S_FETCH));
    step(); step();
    chk("abort_no_write", 32'(wr_count), 32'(wr_before));
    chk("abort_mem", mem[2], rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_ADD));
    reset = 1'b1;
    n = 0;
    do begin step(); n++; end while (m_req !== 1'b1 && n < 5);
    chk("refetch_req", {31'd0, m_req}, 32'd1);
    chk("refetch_addr", 32'(m_addr), 32'd0);
    chk("refetch_pc", pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
